// File: rtl/dl_slp_dac_dig_pkg.sv
// dl_slp_pkg: shared state encoding, default parameters and counter sizing for the charge-integrating DAC sequencer
package dl_slp_pkg;
  typedef enum logic [2:0] {IDLE, DISCHARGE, CHARGE, SETTLE, UPDATE} dac_state_e;
  localparam int DEF_RESOLUTION = 8;
  localparam int DEF_RST_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  function automatic int cnt_width(int res, int rc, int sc);
    int w;
    w = res;
    w = ($clog2(rc) > w) ? $clog2(rc) : w;
    w = ($clog2(sc) > w) ? $clog2(sc) : w;
    return w;
  endfunction
endpackage

// File: rtl/dl_slp_dac_dig_if.sv
// dl_slp_dac_dig_if: request/code inputs and analog-control outputs of the DAC sequencer; master drives start/dig_in, slave is the sequencer
interface dl_slp_dac_dig_if #(parameter int RESOLUTION = 8);
  logic start;
  logic [RESOLUTION-1:0] dig_in;
  logic busy;
  logic cap_rstn;
  logic charge_en;
  logic sample_hold;
  logic eoc;
  logic [RESOLUTION-1:0] code_q;
  modport master(output start, dig_in, input busy, cap_rstn, charge_en, sample_hold, eoc, code_q);
  modport slave(input start, dig_in, output busy, cap_rstn, charge_en, sample_hold, eoc, code_q);
endinterface

// File: rtl/dl_slp_dac_dig_phase_cnt.sv
// dl_slp_phase_cnt: loadable down-counter with zero flag; ports clk, rst, load/load_val (reload), en (count), zero (count==0)
module dl_slp_phase_cnt #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/dl_slp_dac_dig.sv
// dl_slp_dac_dig: DAC sequencer (discharge, charge for code cycles, settle, sample/hold); ports clk, rst, bus (start/dig_in in; busy, cap_rstn, charge_en, sample_hold, eoc, code_q out)
module dl_slp_dac_dig
  import dl_slp_pkg::*;
#(
  parameter int RESOLUTION    = DEF_RESOLUTION,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic clk,
  input logic rst,
  dl_slp_dac_dig_if.slave bus
);
  localparam int W = cnt_width(RESOLUTION, RST_CYCLES, SETTLE_CYCLES);
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_DISCHARGE = DISCHARGE;
  localparam logic [2:0] ST_CHARGE = CHARGE;
  localparam logic [2:0] ST_SETTLE = SETTLE;
  localparam logic [2:0] ST_UPDATE = UPDATE;
  localparam logic [W-1:0] RST_LD = W'(RST_CYCLES - 1);
  localparam logic [W-1:0] SET_LD = W'(SETTLE_CYCLES - 1);
  logic [2:0] state, nxt;
  logic [RESOLUTION-1:0] code_q;
  logic load, zero;
  logic [W-1:0] load_val;
  always_comb begin
    nxt = state;
    load = 1'b0;
    load_val = SET_LD;
    case (state)
      ST_IDLE: if (bus.start) begin
        nxt = ST_DISCHARGE;
        load = 1'b1;
        load_val = RST_LD;
      end
      ST_DISCHARGE: if (zero) begin
        load = 1'b1;
        nxt = (code_q != '0) ? ST_CHARGE : ST_SETTLE;
        load_val = (code_q != '0) ? W'(code_q) - W'(1) : SET_LD;
      end
      ST_CHARGE: if (zero) begin
        load = 1'b1;
        nxt = ST_SETTLE;
      end
      ST_SETTLE: nxt = zero ? ST_UPDATE : ST_SETTLE;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      code_q <= '0;
    end else begin
      state <= nxt;
      code_q <= (state == ST_IDLE && bus.start) ? bus.dig_in : code_q;
    end
  dl_slp_phase_cnt #(.W(W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .en(state != ST_IDLE),
    .zero(zero)
  );
  // Every output decodes the state register only, so async reset clears them at once
  assign bus.busy = state != ST_IDLE;
  assign bus.cap_rstn = state == ST_CHARGE || state == ST_SETTLE || state == ST_UPDATE;
  assign bus.charge_en = state == ST_CHARGE;
  assign bus.sample_hold = state == ST_UPDATE;
  assign bus.eoc = state == ST_UPDATE;
  assign bus.code_q = code_q;
endmodule

// File: tb/tb_dl_slp_dac_dig.sv
// tb_dl_slp_dac_dig: randomized and directed self-checking bench against a busy-span position model
module tb_dl_slp_dac_dig;
  localparam int RC = 4;
  localparam int SC = 2;
  logic clk = 0;
  logic rst = 1;
  dl_slp_dac_dig_if #(.RESOLUTION(8)) bus();
  dl_slp_dac_dig #(.RESOLUTION(8), .RST_CYCLES(RC), .SETTLE_CYCLES(SC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int k = 0, len = 0;
  logic [7:0] code = 0;
  int span = 0, chg = 0, idle = 0, last_span = 0, last_chg = 0, last_idle = 0, eocs = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [12:0] exp_vec();
    return {k > 0, k > RC, k > RC && k <= RC + int'(code), k > 0 && k == len, k > 0 && k == len, code};
  endfunction
  function automatic logic [12:0] dut_vec();
    return {bus.busy, bus.cap_rstn, bus.charge_en, bus.sample_hold, bus.eoc, bus.code_q};
  endfunction
  task automatic step();
    @(posedge clk);
    if (rst) begin
      k = 0;
      code = 0;
    end else if (k == 0) begin
      if (bus.start) begin
        code = bus.dig_in;
        len = RC + int'(bus.dig_in) + SC + 1;
        k = 1;
      end
    end else k = (k == len) ? 0 : k + 1;
    @(negedge clk);
    chk("outs", 32'(dut_vec()), 32'(exp_vec()));
    if (rst) begin
      span = 0;
      chg = 0;
    end else if (bus.busy) begin
      if (span == 0) begin
        last_idle = idle;
        idle = 0;
      end
      span++;
      chg += int'(bus.charge_en);
    end else begin
      if (span > 0) begin
        last_span = span;
        last_chg = chg;
        span = 0;
        chg = 0;
      end
      idle++;
    end
    if (bus.eoc) eocs++;
  endtask
  task automatic wait_idle(string tag);
    int n = 0;
    while (bus.busy && n < 600) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(bus.busy), 0);
  endtask
  task automatic conv(logic [7:0] c);
    bus.start = 1;
    bus.dig_in = c;
    step();
    bus.start = 0;
    wait_idle("conv");
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.start = 0;
    bus.dig_in = 0;
    step();
    step();
    @(negedge clk);
    rst = 0;
    step();
    eocs = 0;
    conv(8'h00);
    chk("s1_span", last_span, 7);
    chk("s1_chg", last_chg, 0);
    chk("s1_eoc", eocs, 1);
    step();
    eocs = 0;
    conv(8'h05);
    chk("s2_span", last_span, 12);
    chk("s2_chg", last_chg, 5);
    chk("s2_code", 32'(bus.code_q), 5);
    chk("s2_eoc", eocs, 1);
    step();
    eocs = 0;
    conv(8'hFF);
    chk("s3_span", last_span, 262);
    chk("s3_chg", last_chg, 255);
    chk("s3_eoc", eocs, 1);
    step();
    step();
    eocs = 0;
    bus.start = 1;
    bus.dig_in = 8'h03;
    step();
    step();
    step();
    bus.dig_in = 8'hAA;
    wait_idle("s4a");
    chk("s4_chg1", last_chg, 3);
    chk("s4_code1", 32'(bus.code_q), 3);
    step();
    chk("s4_idle", last_idle, 1);
    bus.start = 0;
    wait_idle("s4b");
    chk("s4_chg2", last_chg, 170);
    chk("s4_span2", last_span, 177);
    chk("s4_eoc", eocs, 2);
    step();
    bus.start = 1;
    bus.dig_in = 8'h80;
    step();
    bus.start = 0;
    n = 0;
    while (chg < 10 && n < 100) begin
      step();
      n++;
    end
    chk("s5_reach", chg, 10);
    eocs = 0;
    rst = 1;
    k = 0;
    code = 0;
    #1;
    chk("s5_async", 32'(dut_vec()), 32'(exp_vec()));
    step();
    step();
    @(negedge clk);
    rst = 0;
    step();
    step();
    chk("s5_noeoc", eocs, 0);
    conv(8'h02);
    chk("s5_span", last_span, 9);
    step();
    eocs = 0;
    bus.start = 1;
    bus.dig_in = 8'h10;
    step();
    bus.start = 0;
    step();
    bus.start = 1;
    bus.dig_in = 8'h44;
    step();
    bus.start = 0;
    n = 0;
    while (!bus.eoc && n < 100) begin
      step();
      n++;
    end
    chk("s6_reach", 32'(bus.eoc), 1);
    bus.start = 1;
    bus.dig_in = 8'h33;
    step();
    bus.start = 0;
    step();
    chk("s6_span", last_span, 23);
    chk("s6_code", 32'(bus.code_q), 32'h10);
    chk("s6_eoc", eocs, 1);
    for (int i = 0; i < 800; i++) begin
      bus.start = $urandom_range(0, 3) == 0;
      bus.dig_in = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      step();
    end
    bus.start = 0;
    wait_idle("rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dl_slp_dac_dig.md
Name: dl_slp_dac_dig

Overview:
Digital sequencer for the charge-integrating DAC. It is the reverse direction of the dual-slope ADC: a digital code comes in, and an analog level on a hold capacitor comes out.
- A parallel code is latched on start.
- The integrator capacitor is discharged, then charged from a constant current source for exactly `code` clock cycles.
- After settling, the block strobes a sample/hold onto the analog output and pulses eoc.
- It drives the real-valued analog model (dl_slp_dac_ana) inside the DAC top, mirroring the ADC's split into analog and digital halves.

Parameters:
- RESOLUTION, 8: code width; the maximum charge time is 2^RESOLUTION-1 cycles.
- RST_CYCLES, 4: cycles the capacitor is held discharged before charging; must be >= 1.
- SETTLE_CYCLES, 2: cycles between the end of charge and the hold strobe; must be >= 1.

Ports:
- clk  input  1  conversion clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request, level-sampled; honoured only when busy=0.
- dig_in  input  RESOLUTION  code to convert; sampled only in the cycle start is accepted.
- busy  output  1  conversion in progress.
- cap_rstn  output  1  active-low integrator discharge to the analog model.
- charge_en  output  1  connects the current source to the integrator.
- sample_hold  output  1  one-cycle strobe copying the integrator voltage to the held output.
- eoc  output  1  one-cycle end-of-conversion pulse.
- code_q  output  RESOLUTION  latched code of the current or last conversion.

Behaviour:
- Reset and clocking: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy=0, cap_rstn=0, charge_en=0, sample_hold=0, eoc=0, code_q=0, phase counter=0.
- All outputs are registered and decoded from the state register; there are no combinational input-to-output paths.
- IDLE:
  - cap_rstn=0, busy=0.
  - If start=1 at an edge: load code_q<=dig_in, load counter<=RST_CYCLES-1, go to DISCHARGE.
- DISCHARGE:
  - cap_rstn=0, busy=1.
  - Lasts exactly RST_CYCLES cycles.
  - Exit to CHARGE with counter<=code_q-1 if code_q!=0; otherwise go directly to SETTLE with counter<=SETTLE_CYCLES-1.
- CHARGE:
  - cap_rstn=1, charge_en=1, busy=1.
  - Lasts exactly code_q cycles; the counter counts down to 0.
  - Exit to SETTLE with counter<=SETTLE_CYCLES-1.
- SETTLE:
  - cap_rstn=1, charge_en=0, busy=1.
  - Lasts exactly SETTLE_CYCLES cycles, then go to UPDATE.
- UPDATE:
  - Single cycle: sample_hold=1, eoc=1, busy=1, cap_rstn=1.
  - Next state is IDLE unconditionally.
- Latency and back-to-back operation:
  - The busy-high span is RST_CYCLES + code_q + SETTLE_CYCLES + 1 cycles; eoc occurs in its last cycle.
  - With start held high, there is exactly one idle cycle (busy=0) between conversions.
- Ignored inputs:
  - start while busy=1, including during the UPDATE cycle, is ignored; there is no queueing.
  - dig_in changes while busy have no effect.
- Counter width and sizing:
  - The counter width is max(RESOLUTION, $clog2(RST_CYCLES), $clog2(SETTLE_CYCLES)) bits.
  - code_q = 2^RESOLUTION-1 gives exactly that many charge cycles, with no wrap.
- charge_en and cap_rstn are never simultaneously in the charge-while-discharging combination (charge_en=1 with cap_rstn=0) in any state.
- Reset mid-conversion:
  - All outputs return to their reset values immediately (asynchronously).
  - The aborted conversion produces no eoc and no sample_hold; the held analog output keeps its previous value.
  - After rst deasserts, the next start converts normally.

Decomposition:
- Package dl_slp_pkg:
  - typedef enum logic [2:0] dac_state_e {IDLE, DISCHARGE, CHARGE, SETTLE, UPDATE}.
  - Default parameter constants.
  - Function cnt_width() returning the counter width.
- Sub-module dl_slp_phase_cnt: loadable down-counter with a zero flag (inputs load, load_val, en; output zero), reused for all three timed phases.
- The FSM and output decode stay in dl_slp_dac_dig.

Test Plan:
All scenarios use RESOLUTION=8, RST_CYCLES=4, SETTLE_CYCLES=2.
1. start 1 cycle, dig_in=0x00 -> busy 7 cycles, charge_en never 1, cap_rstn=0 for first 4 busy cycles, sample_hold and eoc in 7th busy cycle only.
2. start, dig_in=0x05 -> busy 12 cycles, charge_en=1 for exactly busy cycles 5-9, eoc in cycle 12, code_q=0x05.
3. start, dig_in=0xFF -> charge_en=1 for exactly 255 consecutive cycles, busy 262 cycles, one eoc.
4. start held high, dig_in=0x03 then changed to 0xAA mid-conversion -> first conversion charges 3 cycles; busy low exactly 1 cycle; second conversion charges 0xAA=170 cycles.
5. dig_in=0x80, rst pulsed at 10th CHARGE cycle -> all outputs at reset values during rst, no eoc; next start with 0x02 gives busy 9 cycles.
6. start re-pulsed at busy cycles 3 and during UPDATE, dig_in=0x10 -> ignored, exactly one eoc, code_q=0x10, busy 23 cycles.
